mips_dmem_responder: RTL and testbench
======================================

Name: mips_dmem_responder

Overview:
- Data-memory responder on the MEM stage of the 5-stage MIPS pipeline: the memory side of the mem_ren/mem_wen request issued per instruction.
- Services word loads and stores after a configurable number of wait states.
- Raises mem_stall while busy so the pipeline controller freezes IF/ID/EXE/MEM.
- Flags misaligned, out-of-range and conflicting requests.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words
WAIT_CYCLES, 2, wait states per access; legal range 1..15

Ports:
clk  input  1  main clock
rst  input  1  reset, asynchronous, active-low
mem_ren  input  1  read request from MEM stage
mem_wen  input  1  write request from MEM stage
mem_addr  input  32  byte address (ALU result)
mem_din  input  32  store data
mem_dout  output  32  load data, valid while mem_ack=1, held afterwards
mem_ack  output  1  one-cycle completion pulse
mem_err  output  1  one-cycle error pulse, coincident with mem_ack
mem_stall  output  1  stall request to the pipeline controller

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; counter=0.
  - mem_dout=0; mem_ack=0; mem_err=0; mem_stall=0.
  - Memory array is not cleared.
  - Reset mid-access aborts the access; no write is committed.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mem_stall = mem_ren | mem_wen (combinational).
  - On a request, latch addr, din and rd/wr type.
  - Bad request: ren & wen both set, or addr[1:0] != 0, or addr[31:ADDR_WIDTH+2] != 0.
    - Go to DONE with the error flag set.
    - No memory access.
    - Stall lasts 1 cycle.
  - Good request: go to BUSY, counter = WAIT_CYCLES-1.
- BUSY:
  - mem_stall=1.
  - Counter decrements each cycle.
  - At counter==0, go to DONE.
  - On the edge entering DONE:
    - Read: mem_dout <= array[addr[ADDR_WIDTH+1:2]].
    - Write: array[...] <= din.
- DONE:
  - mem_stall=0; mem_ack=1; mem_err=error flag.
  - Always returns to IDLE next cycle.
  - A request present in DONE belongs to the released instruction and is ignored.
  - A back-to-back request starts in the following IDLE cycle.
- Latency: request first seen in IDLE at cycle T.
  - DONE (ack) occurs at T+WAIT_CYCLES+1.
  - mem_stall is high from T through T+WAIT_CYCLES inclusive.
- Request inputs are sampled only in IDLE; changes during BUSY are ignored.
- The error path does not update mem_dout.
- mem_ack and mem_err are registered, derived from the state register.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- When defined, three extra outputs are added:
  - perf_rd_cnt [31:0]: increments on each good read ack.
  - perf_wr_cnt [31:0]: increments on each good write ack.
  - perf_stall_cnt [31:0]: increments each cycle mem_stall=1.
- All three clear on reset and saturate at 32'hFFFFFFFF.
- When undefined, the ports and logic are absent; base behaviour is identical.

Test Plan:
1. Reset, then write addr 0x10 data 0xDEADBEEF (WAIT_CYCLES=2) -> mem_stall high 3 cycles; ack on 4th cycle, err=0. Then read 0x10 -> mem_dout=0xDEADBEEF with ack, same timing.
2. Read addr 0x13 (misaligned) -> stall 1 cycle; next cycle ack=1, err=1; mem_dout unchanged; no array change.
3. ren=wen=1 at 0x20, and separately read at 0x1000 (beyond 4 KiB) -> each gives err=1 with ack after 1 stall cycle; 0x20 contents unchanged.
4. Back-to-back: write 0x0=5, then read 0x0 presented in the DONE cycle -> second access starts the cycle after DONE; returns 5; exactly two ack pulses.
5. Assert rst=0 in the middle of BUSY of a write to 0x40 (prior content 0x1) -> outputs 0 immediately (asynchronous); later read of 0x40 returns 0x1.
6. With DMEM_PERF_CNT_EN, WAIT_CYCLES=1: 2 reads + 1 write -> perf_rd_cnt=2, perf_wr_cnt=1, perf_stall_cnt=6.

Source files
------------

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: MEM-stage data memory with fixed wait states.
// A good request stalls the pipeline for WAIT_CYCLES+1 cycles and then gives a
// one-cycle mem_ack. A bad request (misaligned, out of range, or read and
// write together) stalls for one cycle and then acks with mem_err set.
// Optional macro DMEM_PERF_CNT_EN adds saturating read/write/stall counters.
module mips_dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_din,
   output logic [31:0] mem_dout,
   output logic        mem_ack,
   output logic        mem_err,
   output logic        mem_stall
`ifdef DMEM_PERF_CNT_EN
   ,
   output logic [31:0] perf_rd_cnt,
   output logic [31:0] perf_wr_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             din_q, din_d;
   logic                    wr_q, wr_d;
   logic                    err_q, err_d;
   logic [31:0]             dout_q;
   logic [31:0]             mem_q [2**ADDR_WIDTH];

   logic                    req;
   logic                    bad_req;
   logic                    access_end;

   assign req        = mem_ren | mem_wen;
   assign bad_req    = (mem_ren & mem_wen) | (mem_addr[1:0] != 2'b00) |
                       ((mem_addr >> (ADDR_WIDTH + 2)) != '0);
   // Last BUSY cycle: the array is read or written on the edge into DONE.
   assign access_end = (state_q == BUSY) && (cnt_q == 4'd0);

   // State, counter and latched request registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic, request capture in IDLE and the stall request.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      din_d     = din_q;
      wr_d      = wr_q;
      err_d     = err_q;
      mem_stall = 1'b0;
      unique case (state_q)
         IDLE: begin
            mem_stall = req;
            if (req) begin
               addr_d = mem_addr[ADDR_WIDTH+1:2];
               din_d  = mem_din;
               wr_d   = mem_wen;
               err_d  = bad_req;
               if (bad_req) begin
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            mem_stall = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Load data register; held between reads, untouched by writes and errors.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q <= '0;
      end else if (access_end && !wr_q) begin
         dout_q <= mem_q[addr_q];
      end
   end

   // Storage array; not cleared by reset.
   always_ff @(posedge clk) begin
      if (access_end && wr_q) begin
         mem_q[addr_q] <= din_q;
      end
   end

   assign mem_dout = dout_q;
   assign mem_ack  = (state_q == DONE);
   assign mem_err  = (state_q == DONE) & err_q;

`ifdef DMEM_PERF_CNT_EN
   logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;

   // Saturating counters for good reads, good writes and stalled cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_rd_q    <= '0;
         perf_wr_q    <= '0;
         perf_stall_q <= '0;
      end else begin
         if (mem_ack && !err_q && !wr_q && (perf_rd_q != '1)) begin
            perf_rd_q <= perf_rd_q + 32'd1;
         end
         if (mem_ack && !err_q && wr_q && (perf_wr_q != '1)) begin
            perf_wr_q <= perf_wr_q + 32'd1;
         end
         if (mem_stall && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_rd_cnt    = perf_rd_q;
   assign perf_wr_cnt    = perf_wr_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder (ADDR_WIDTH=10).
// Honours DMEM_PERF_CNT_EN: when defined the DUT runs with WAIT_CYCLES=1 and
// the performance counters are checked as well.
module tb_mips_dmem_responder;

   localparam int unsigned AW = 10;
`ifdef DMEM_PERF_CNT_EN
   localparam int unsigned W = 1;
`else
   localparam int unsigned W = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_ren = 1'b0;
   logic        mem_wen = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_din = '0;
   logic [31:0] mem_dout;
   logic        mem_ack;
   logic        mem_err;
   logic        mem_stall;
`ifdef DMEM_PERF_CNT_EN
   logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

   mips_dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_ren  (mem_ren),
      .mem_wen  (mem_wen),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .mem_ack  (mem_ack),
      .mem_err  (mem_err),
      .mem_stall(mem_stall)
`ifdef DMEM_PERF_CNT_EN
      ,
      .perf_rd_cnt   (perf_rd_cnt),
      .perf_wr_cnt   (perf_wr_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [31:0] d;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] mem_m [2**AW];
   logic [31:0] last_dout = '0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned ack_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every ack pops one expected response.
   always @(negedge clk) begin
      if (rst && mem_ack) begin
         ack_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("dout", mem_dout, e.d);
            check("err", {31'd0, mem_err}, {31'd0, e.err});
         end
      end
   end

   // Issue one request just after a negedge; skip = cycles the request is
   // presented before the DUT is back in IDLE (e.g. presented during DONE).
   // Returns just after the negedge of the ack cycle.
   task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] din, input int unsigned skip);
      logic        bad;
      logic [31:0] addr_v;
      logic [AW-1:0] idx;
      exp_t        e;
      int unsigned lat, stalls;
      bit          seen;
      addr_v = addr;
      idx    = addr_v[AW+1:2];
      bad    = (ren && wen) || (addr_v[1:0] != 2'b00) || ((addr_v >> (AW + 2)) != 0);
      e.err  = bad;
      if (!bad && ren) begin
         e.d       = mem_m[idx];
         last_dout = mem_m[idx];
      end else begin
         e.d = last_dout;
      end
      if (!bad && wen) mem_m[idx] = din;
      exp_q.push_back(e);

      mem_ren  = ren;
      mem_wen  = wen;
      mem_addr = addr;
      mem_din  = din;
      lat = 0; stalls = 0; seen = 0;
      repeat (skip) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      for (int c = 0; c < 40 && !seen; c++) begin
         #1;
         if (mem_ack) begin
            seen = 1;
         end else begin
            if (mem_stall) stalls++;
            @(posedge clk); lat++;
            @(negedge clk);
            if (lat == 1 + skip) begin
               mem_ren = 1'b0;
               mem_wen = 1'b0;
               mem_addr = '0;
               mem_din = '0;
            end
         end
      end
      if (!seen) check("ack_timeout", 32'd0, 32'd1);
      check("latency", lat, bad ? 1 + skip : W + 1 + skip);
      check("stall_cycles", stalls, bad ? 32'd1 : W + 1);
   endtask

   task automatic access_gap(input logic ren, input logic wen, input logic [31:0] addr,
                             input logic [31:0] din);
      access(ren, wen, addr, din, 0);
      @(negedge clk);
   endtask

   initial begin
      int unsigned a0;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_dout", mem_dout, 32'd0);
      check("rst_ack", {31'd0, mem_ack}, 32'd0);
      check("rst_err", {31'd0, mem_err}, 32'd0);
      check("rst_stall", {31'd0, mem_stall}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // 1: write then read
      access_gap(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      access_gap(1'b1, 1'b0, 32'h10, 32'h0);

      // 2: misaligned read, dout held, array unchanged
      access_gap(1'b1, 1'b0, 32'h13, 32'h0);
      access_gap(1'b1, 1'b0, 32'h10, 32'h0);

      // 3: conflicting request at 0x20 and out-of-range read
      access_gap(1'b0, 1'b1, 32'h20, 32'h12345678);
      access_gap(1'b1, 1'b1, 32'h20, 32'hFFFF0000);
      access_gap(1'b1, 1'b0, 32'h1000, 32'h0);
      access_gap(1'b0, 1'b1, 32'h1004, 32'hABCD0000);
      access_gap(1'b1, 1'b0, 32'h20, 32'h0);
      access_gap(1'b1, 1'b0, 32'hFFC, 32'h0);   // last word, uninitialised is fine? written below first
      // boundary: last legal word write/read
      access_gap(1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D);
      access_gap(1'b1, 1'b0, 32'hFFC, 32'h0);

      // 4: back-to-back, second request presented during DONE
      a0 = ack_cnt;
      access(1'b0, 1'b1, 32'h0, 32'd5, 0);
      access(1'b1, 1'b0, 32'h0, 32'h0, 1);
      repeat (4) @(negedge clk);
      check("b2b_ack_count", ack_cnt - a0, 32'd2);

      // 5: reset during BUSY of a write aborts it
      access_gap(1'b0, 1'b1, 32'h40, 32'h1);
      mem_wen = 1'b1; mem_addr = 32'h40; mem_din = 32'h99;
      @(posedge clk);
      @(negedge clk);
      mem_wen = 1'b0; mem_addr = '0; mem_din = '0;
      #2 rst = 1'b0;
      #1;
      check("arst_ack", {31'd0, mem_ack}, 32'd0);
      check("arst_err", {31'd0, mem_err}, 32'd0);
      check("arst_stall", {31'd0, mem_stall}, 32'd0);
      check("arst_dout", mem_dout, 32'd0);
      last_dout = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      access_gap(1'b1, 1'b0, 32'h40, 32'h0);

`ifdef DMEM_PERF_CNT_EN
      // 6: performance counters after 1 write + 2 reads
      rst = 1'b0;
      last_dout = '0;
      @(negedge clk);
      check("perf_rst_rd", perf_rd_cnt, 32'd0);
      check("perf_rst_stall", perf_stall_cnt, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      access_gap(1'b0, 1'b1, 32'h8, 32'h77);
      access_gap(1'b1, 1'b0, 32'h8, 32'h0);
      access_gap(1'b1, 1'b0, 32'h8, 32'h0);
      check("perf_rd", perf_rd_cnt, 32'd2);
      check("perf_wr", perf_wr_cnt, 32'd1);
      check("perf_stall", perf_stall_cnt, 32'd6);
      access_gap(1'b1, 1'b0, 32'h9, 32'h0);
      check("perf_rd_err", perf_rd_cnt, 32'd2);
      check("perf_stall_err", perf_stall_cnt, 32'd7);
`endif

      repeat (3) @(negedge clk);
      check("sb_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
